// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline controller: stall (hold) levels driven to
// the PC and stage registers, the controller state encoding, and the reset
// vector used for address registers.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Hold levels, ordered so that a larger value stalls more of the pipeline.
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  // RUN   : normal flow, redirects accepted from EX and the interrupt unit.
  // PEND  : a redirect is waiting for the fetch bus to become ready.
  // FLUSH : a redirect was issued; wrong-path slots are being squashed.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // The PC and stage registers honour the strongest stall requested.
  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Turns each rising edge of trig_i into a registered pulse exactly
// WIDTH_CYCLES cycles wide, starting the cycle after the edge. A new edge
// while the pulse is active restarts the full width.
//
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset
//   trig_i  in   trigger (level or pulse; only rising edges matter)
//   level_o out  stretched pulse, registered
// -----------------------------------------------------------------------------
module pulse_stretch #(
  parameter int unsigned WIDTH_CYCLES = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  output logic level_o
);

  logic             trig_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             rise;

  assign rise = trig_i & ~trig_q;

  // NOTE: cnt_d gets its default before any branch so no path leaves it
  // unassigned; a missing default in combinational logic infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_W'(WIDTH_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      trig_q  <= trig_i;
      cnt_q   <= cnt_d;
      // Registered so the output is glitch-free; equals (cnt_q != 0).
      level_q <= (cnt_d != '0);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline controller. Arbitrates redirects and stalls from EX, the
// interrupt controller, the instruction bus and the debug module; drives the
// PC register and flushes the IF/ID and ID/EX stage registers. A redirect that
// arrives while the fetch bus is stalled is parked in PEND and issued on the
// first bus-ready cycle. Debugger reset requests are stretched to RST_CYCLES.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   ex_jump_req_i / ex_jump_addr_i      taken branch/jump from EX
//   ex_hold_req_i                       EX multi-cycle op busy
//   int_jump_req_i / int_jump_addr_i    interrupt entry / mret redirect
//   int_hold_req_i                      interrupt controller writing CSRs
//   bus_hold_req_i                      instruction bus not ready
//   jtag_halt_req_i                     debugger halt
//   jtag_reset_req_i                    debugger core reset
//   jump_flag_o / jump_addr_o           redirect to the PC register
//   hold_flag_o                         stall level (HOLD_*)
//   jtag_reset_flag_o                   stretched core reset, registered
//   flush_o                             squash IF/ID and ID/EX
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RST_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_jump_req_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_hold_req_i,
  input  logic        int_jump_req_i,
  input  logic [31:0] int_jump_addr_i,
  input  logic        int_hold_req_i,
  input  logic        bus_hold_req_i,
  input  logic        jtag_halt_req_i,
  input  logic        jtag_reset_req_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o,
  output logic        jtag_reset_flag_o,
  output logic        flush_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        rst_active;
  logic        id_hold_req;
  logic        freeze;
  logic [31:0] winner_addr;

  // ---------------------------------------------------------------------------
  // JTAG reset stretcher
  // ---------------------------------------------------------------------------
  pulse_stretch #(
    .WIDTH_CYCLES (RST_CYCLES),
    .CNT_W        (4)
  ) u_jtag_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig_i  (jtag_reset_req_i),
    .level_o (jtag_reset_flag_o)
  );

  assign rst_active = jtag_reset_flag_o;

  // ---------------------------------------------------------------------------
  // Stall level
  // ---------------------------------------------------------------------------
  assign id_hold_req = ex_hold_req_i | int_hold_req_i | jtag_halt_req_i | rst_active;

  assign hold_flag_o = hold_max(id_hold_req    ? HOLD_ID : HOLD_NONE,
                                bus_hold_req_i ? HOLD_PC : HOLD_NONE);

  // Stall cycles do not advance the squash window: the slots behind a
  // stalled IF/ID are the same wrong-path slots, not fresh ones.
  assign freeze = (hold_flag_o >= HOLD_IF);

  // Interrupt redirects win over EX redirects.
  assign winner_addr = int_jump_req_i ? int_jump_addr_i : ex_jump_addr_i;

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pend_addr_d = pend_addr_q;
    jump_flag_o = 1'b0;
    jump_addr_o = RESET_VECTOR;
    flush_o     = 1'b0;

    if (rst_active) begin
      // The core is being reset: drop any redirect in flight and keep the
      // stage registers empty.
      state_d     = RUN;
      fcnt_d      = '0;
      pend_addr_d = RESET_VECTOR;
      flush_o     = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (int_jump_req_i || ex_jump_req_i) begin
            flush_o = 1'b1;
            if (!bus_hold_req_i) begin
              jump_flag_o = 1'b1;
              jump_addr_o = winner_addr;
              fcnt_d      = FLUSH_LOAD;
              state_d     = FLUSH;
            end else begin
              pend_addr_d = winner_addr;
              state_d     = PEND;
            end
          end
        end

        PEND: begin
          // Anything EX resolves now is on the wrong path; only an interrupt
          // can replace the parked target.
          flush_o = 1'b1;
          if (int_jump_req_i) begin
            pend_addr_d = int_jump_addr_i;
          end
          if (!bus_hold_req_i) begin
            jump_flag_o = 1'b1;
            jump_addr_o = int_jump_req_i ? int_jump_addr_i : pend_addr_q;
            fcnt_d      = FLUSH_LOAD;
            state_d     = FLUSH;
          end
        end

        FLUSH: begin
          flush_o = 1'b1;
          if (int_jump_req_i) begin
            if (!bus_hold_req_i) begin
              jump_flag_o = 1'b1;
              jump_addr_o = int_jump_addr_i;
              fcnt_d      = FLUSH_LOAD;
            end else begin
              pend_addr_d = int_jump_addr_i;
              fcnt_d      = '0;
              state_d     = PEND;
            end
          end else if (!freeze) begin
            if (fcnt_q <= 3'd1) begin
              fcnt_d  = '0;
              state_d = RUN;
            end else begin
              fcnt_d = fcnt_q - 3'd1;
            end
          end
        end

        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      pend_addr_q <= RESET_VECTOR;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_addr_q <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed scenarios followed by randomized traffic, compared every cycle
// against a behavioural model that tracks "is a redirect parked", "how many
// squash slots remain" and "how many reset cycles remain".
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int F = 2;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;
  logic        ex_hold_req;
  logic        int_jump_req;
  logic [31:0] int_jump_addr;
  logic        int_hold_req;
  logic        bus_hold_req;
  logic        jtag_halt_req;
  logic        jtag_reset_req;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic        jtag_reset_flag;
  logic        flush;

  pipe_ctrl #(
    .FLUSH_CYCLES (F),
    .RST_CYCLES   (R)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_jump_req_i     (ex_jump_req),
    .ex_jump_addr_i    (ex_jump_addr),
    .ex_hold_req_i     (ex_hold_req),
    .int_jump_req_i    (int_jump_req),
    .int_jump_addr_i   (int_jump_addr),
    .int_hold_req_i    (int_hold_req),
    .bus_hold_req_i    (bus_hold_req),
    .jtag_halt_req_i   (jtag_halt_req),
    .jtag_reset_req_i  (jtag_reset_req),
    .jump_flag_o       (jump_flag),
    .jump_addr_o       (jump_addr),
    .hold_flag_o       (hold_flag),
    .jtag_reset_flag_o (jtag_reset_flag),
    .flush_o           (flush)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Behavioural model state.
  bit          m_pending;
  logic [31:0] m_target;
  int          m_squash;
  int          m_rst_left;
  bit          m_prev_jreq;

  // Expected outputs for the current cycle.
  logic        e_jf;
  logic [31:0] e_addr;
  logic [2:0]  e_hold;
  logic        e_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pending   = 1'b0;
    m_target    = 32'h0;
    m_squash    = 0;
    m_rst_left  = 0;
    m_prev_jreq = 1'b0;
  endtask

  task automatic model_expect();
    bit rst_on;
    bit id_req;
    rst_on = (m_rst_left > 0);
    id_req = ex_hold_req || int_hold_req || jtag_halt_req || rst_on;
    e_hold  = id_req ? 3'd3 : (bus_hold_req ? 3'd1 : 3'd0);
    e_jf    = 1'b0;
    e_addr  = 32'h0;
    e_flush = 1'b0;
    if (rst_on) begin
      e_flush = 1'b1;
    end else if (m_pending) begin
      e_flush = 1'b1;
      if (!bus_hold_req) begin
        e_jf   = 1'b1;
        e_addr = int_jump_req ? int_jump_addr : m_target;
      end
    end else if (int_jump_req || (ex_jump_req && m_squash == 0)) begin
      e_flush = 1'b1;
      if (!bus_hold_req) begin
        e_jf   = 1'b1;
        e_addr = int_jump_req ? int_jump_addr : ex_jump_addr;
      end
    end else begin
      e_flush = (m_squash > 0);
    end
  endtask

  // Applies one clock edge to the model using the inputs held across it.
  task automatic model_update();
    bit rst_on;
    bit rise;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rst_on      = (m_rst_left > 0);
    rise        = jtag_reset_req && !m_prev_jreq;
    m_prev_jreq = jtag_reset_req;
    if (rst_on) begin
      m_pending = 1'b0;
      m_squash  = 0;
    end else if (m_pending) begin
      if (!bus_hold_req) begin
        m_pending = 1'b0;
        m_squash  = F;
      end else if (int_jump_req) begin
        m_target = int_jump_addr;
      end
    end else if (int_jump_req || (ex_jump_req && m_squash == 0)) begin
      if (bus_hold_req) begin
        m_pending = 1'b1;
        m_target  = int_jump_req ? int_jump_addr : ex_jump_addr;
        m_squash  = 0;
      end else begin
        m_squash = F;
      end
    end else if (m_squash > 0 && e_hold < 3'd2) begin
      m_squash--;
    end
    if (rise) m_rst_left = R;
    else if (m_rst_left > 0) m_rst_left--;
  endtask

  // One cycle: compare at the falling edge, advance the model at the rising
  // edge, then release inputs for the next step shortly after.
  task automatic step();
    @(negedge clk);
    model_expect();
    check("jump_flag",       32'(jump_flag),       32'(e_jf));
    check("jump_addr",       jump_addr,            e_addr);
    check("hold_flag",       32'(hold_flag),       32'(e_hold));
    check("flush",           32'(flush),           32'(e_flush));
    check("jtag_reset_flag", 32'(jtag_reset_flag), 32'(m_rst_left > 0));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    rst_n          = 1'b1;
    ex_jump_req    = 1'b0;
    ex_jump_addr   = 32'h0;
    ex_hold_req    = 1'b0;
    int_jump_req   = 1'b0;
    int_jump_addr  = 32'h0;
    int_hold_req   = 1'b0;
    bus_hold_req   = 1'b0;
    jtag_halt_req  = 1'b0;
    jtag_reset_req = 1'b0;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Reset state.
    step();
    check("reset_jump_addr_zero", jump_addr, 32'h0);

    // Plain EX jump: issue, two squash cycles, back to RUN.
    ex_jump_req = 1'b1; ex_jump_addr = 32'h100;
    step();
    set_idle();
    repeat (4) step();

    // Simultaneous EX and interrupt jumps: interrupt wins.
    ex_jump_req = 1'b1;  ex_jump_addr  = 32'h100;
    int_jump_req = 1'b1; int_jump_addr = 32'h200;
    step();
    set_idle();
    repeat (4) step();

    // Redirect deferred behind a bus stall; an EX jump inside PEND ignored.
    bus_hold_req = 1'b1;
    ex_jump_req = 1'b1; ex_jump_addr = 32'h40;
    step();
    ex_jump_req = 1'b0;
    step();
    ex_jump_req = 1'b1; ex_jump_addr = 32'h80;
    step();
    ex_jump_req = 1'b0;
    step();
    bus_hold_req = 1'b0;
    step();
    repeat (3) step();

    // Stall levels: ex_hold, ex_hold + int_hold, bus_hold alone.
    ex_hold_req = 1'b1;
    repeat (2) step();
    int_hold_req = 1'b1;
    repeat (3) step();
    set_idle();
    bus_hold_req = 1'b1;
    repeat (2) step();
    set_idle();
    step();

    // Debugger reset held high for 10 cycles during FLUSH.
    ex_jump_req = 1'b1; ex_jump_addr = 32'h300;
    step();
    set_idle();
    jtag_reset_req = 1'b1;
    repeat (10) step();
    set_idle();
    repeat (3) step();

    // Synchronous reset while a redirect is parked.
    bus_hold_req = 1'b1;
    ex_jump_req = 1'b1; ex_jump_addr = 32'h500;
    step();
    ex_jump_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    set_idle();
    step();
    check("post_reset_no_pending_issue", 32'(jump_flag), 32'h0);
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      ex_jump_req    = ($urandom_range(0, 99) < 20);
      ex_jump_addr   = $urandom & 32'hFFFF_FFFC;
      int_jump_req   = ($urandom_range(0, 99) < 7);
      int_jump_addr  = $urandom & 32'hFFFF_FFFC;
      bus_hold_req   = ($urandom_range(0, 99) < 35);
      ex_hold_req    = ($urandom_range(0, 99) < 10);
      int_hold_req   = ($urandom_range(0, 99) < 5);
      jtag_halt_req  = ($urandom_range(0, 99) < 3);
      jtag_reset_req = ($urandom_range(0, 99) < 4) ? ~jtag_reset_req : jtag_reset_req;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
